mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Multi-cycle MEM-stage controller; successor to the combinational mem-op decode.
//  Decodes LD/ST/STU/HALT from the MEM-stage instruction and drives a
//  request/ready handshake to a variable-latency data memory.
//  Stalls the pipeline while an access is outstanding and flags misaligned/timed-out accesses.
//  Latches HALT as a sticky dump request.
// PARAMETERS
//  DATA_W    16  data bus width (bits)
//  ADDR_W    16  address width (bits)
//  MAX_WAIT  64  max BUSY cycles before timeout; 0 = timeout disabled
//  ALIGN_CHK 1   1 = word accesses require addr[0]==0; 0 = no check
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       async active-low reset
//  valid      in   1       MEM-stage instr valid
//  instr      in   16      MEM-stage instruction
//  addr       in   ADDR_W  effective address
//  wdata      in   DATA_W  store data
//  mem_rdy    in   1       memory done; sampled only while mem_en=1
//  mem_rdata  in   DATA_W  load data; valid when mem_rdy=1
//  mem_en     out  1       memory request (registered)
//  mem_wr     out  1       1 = write, 0 = read (qualifies mem_en)
//  mem_addr   out  ADDR_W  latched address
//  mem_wdata  out  DATA_W  latched store data
//  stall      out  1       hold upstream pipeline
//  rdata      out  DATA_W  registered load result
//  rdata_vld  out  1       1-cycle pulse, load complete
//  halt       out  1       sticky dump request
//  err        out  1       sticky fault
//  err_code   out  2       01 = timeout, 10 = misaligned; 00 = no fault
// BEHAVIOUR
//  Decode: op = instr[15:11]. 10001 = LD; 10000 = ST; 10011 = STU; 00000 = HALT.
//   Other opcodes: no memory action, no stall.
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; wait counter 0.
//   Reset mid-access drops mem_en at once; the access is abandoned.
//  States: IDLE, BUSY, DONE, HALTED, ERR.
//  IDLE:
//   - valid & mem-op & aligned: latch addr/wdata/wr; stall=1 (combinational, same cycle); ->BUSY.
//   - valid & mem-op & misaligned (ALIGN_CHK=1, addr[0]=1): ->ERR, err_code=10, no request.
//   - valid & HALT: ->HALTED.
//   - else: stay in IDLE; stall=0.
//  BUSY: mem_en=1, stall=1; counter increments each cycle.
//   - mem_rdy=1: ->DONE; if LD, rdata<=mem_rdata.
//   - else if MAX_WAIT!=0 and counter reaches MAX_WAIT: ->ERR, err_code=01.
//   - mem_rdy on the MAX_WAIT-th cycle completes normally; it has priority over timeout.
//  DONE (1 cycle): mem_en=0, stall=0, rdata_vld=1 if LD; counter cleared; ->IDLE.
//   Pipeline advances on this edge; next instr is evaluated in IDLE.
//  HALTED: halt=1, stall=1; terminal until reset; valid/instr ignored.
//  ERR: err=1, stall=1, mem_en=0; terminal until reset; err_code holds first fault.
//  Latency: accept cycle N with mem_rdy first high at cycle M (M>=N+1).
//   stall is high N..M; DONE at M+1. Minimum stall = 2 cycles.
//  mem_addr/mem_wdata/mem_wr are stable for the whole BUSY period.
//  ST and STU are identical at this interface.
// TESTING
//  1. LD addr=0x0010, mem_rdy 1 cycle after mem_en -> mem_wr=0, stall 2 cycles, rdata_vld pulse.
//  2. ST addr=0x0020, wdata=0xBEEF, mem_rdy after 5 cycles -> mem_wdata=0xBEEF stable 5 cycles;
//     stall deasserts in DONE.
//  3. LD addr=0x0003, ALIGN_CHK=1 -> mem_en never asserted; err=1, err_code=10, stall stuck at 1.
//  4. MAX_WAIT=4, mem_rdy held low -> ERR after 4 BUSY cycles, err_code=01, mem_en drops.
//     Repeat with mem_rdy on cycle 4 -> completes normally, no error.
//  5. HALT (instr=0x0000) -> halt=1 next cycle, stays high; following LD issues no request.
//  6. rst_n low during BUSY -> mem_en=0 immediately; all outputs 0; IDLE after release; new LD works.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage controller that turns LD/ST/STU into a
// request/ready access to a variable-latency data memory and latches HALT.
// Ports: clk, rst_n (async, active low); valid/instr/addr/wdata from MEM stage;
//        mem_en/mem_wr/mem_addr/mem_wdata request, mem_rdy/mem_rdata response;
//        stall to upstream; rdata/rdata_vld load result; halt, err, err_code.
module mem_access_ctrl #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int MAX_WAIT  = 64,
   parameter int ALIGN_CHK = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid,
   input  logic [15:0]       instr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              mem_rdy,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              stall,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_vld,
   output logic              halt,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam logic [4:0] OP_LD   = 5'b10001;
   localparam logic [4:0] OP_ST   = 5'b10000;
   localparam logic [4:0] OP_STU  = 5'b10011;
   localparam logic [4:0] OP_HALT = 5'b00000;

   localparam logic [1:0] FLT_TMO   = 2'b01;
   localparam logic [1:0] FLT_ALIGN = 2'b10;

   localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BUSY,
      S_DONE,
      S_HALTED,
      S_ERR
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             ld_q;
   logic             stall_c;
   logic [1:0]       fault;

   logic [4:0] op;
   logic       is_ld;
   logic       is_st;
   logic       is_mem;
   logic       is_halt;
   logic       misalign;
   logic       tmo;
   logic       unused_instr;

   assign op       = instr[15:11];
   assign is_ld    = (op == OP_LD);
   assign is_st    = (op == OP_ST) || (op == OP_STU);
   assign is_mem   = is_ld || is_st;
   assign is_halt  = (op == OP_HALT);
   assign misalign = (ALIGN_CHK != 0) && addr[0];

   assign unused_instr = ^instr[10:0];

   // cnt holds the number of BUSY cycles already completed, so cnt_inc
   // is the 1-based index of the current BUSY cycle.
   assign cnt_inc = cnt + 1'b1;
   assign tmo     = (MAX_WAIT != 0) && (cnt_inc == CNT_W'(MAX_WAIT));

   always_comb begin
      state_nxt = state;
      stall_c   = 1'b0;
      fault     = 2'b00;
      unique case (state)
         S_IDLE: begin
            if (valid && is_mem) begin
               // hold the pipeline in the accept cycle itself
               stall_c = 1'b1;
               if (misalign) begin
                  state_nxt = S_ERR;
                  fault     = FLT_ALIGN;
               end else begin
                  state_nxt = S_BUSY;
               end
            end else if (valid && is_halt) begin
               stall_c   = 1'b1;
               state_nxt = S_HALTED;
            end
         end
         S_BUSY: begin
            stall_c = 1'b1;
            // a ready on the last allowed cycle still completes
            if (mem_rdy) begin
               state_nxt = S_DONE;
            end else if (tmo) begin
               state_nxt = S_ERR;
               fault     = FLT_TMO;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         S_HALTED: begin
            stall_c = 1'b1;
         end
         S_ERR: begin
            stall_c = 1'b1;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // stall is combinational; force it low while reset is held
   assign stall = stall_c && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         ld_q      <= 1'b0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
         rdata_vld <= 1'b0;
         halt      <= 1'b0;
         err       <= 1'b0;
         err_code  <= 2'b00;
      end else begin
         state     <= state_nxt;
         mem_en    <= (state_nxt == S_BUSY);
         halt      <= (state_nxt == S_HALTED);
         err       <= (state_nxt == S_ERR);
         rdata_vld <= (state == S_BUSY) && mem_rdy && ld_q;

         if ((state == S_IDLE) && (state_nxt == S_BUSY)) begin
            mem_addr  <= addr;
            mem_wdata <= wdata;
            mem_wr    <= !is_ld;
            ld_q      <= is_ld;
         end

         if (state == S_BUSY) begin
            cnt <= cnt_inc;
            if (mem_rdy && ld_q) begin
               rdata <= mem_rdata;
            end
         end else begin
            cnt <= '0;
         end

         // ERR is terminal, so only the first fault is ever recorded
         if (fault != 2'b00) begin
            err_code <= fault;
         end
      end
   end

endmodule
